safe_level_fsm: RTL and testbench
=================================

Name: safe_level_fsm

Overview:
- Parametrised level-stepping FSM. Successor to the fixed 2-bit combined next-state/output FSM.
- Steps a registered level up or down on decoded user commands, with a configurable level count and input width.
- Adds explicit handling for every state encoding, saturating boundaries, an invalid-command error counter and a timed lockout state.
- Sits between the user command interface and downstream privilege/mode logic, which consumes `out` and `locked`.

Parameters:
IN_W, 3, width of user_input command field (>=2)
ST_W, 3, width of state encoding and out
NUM_LEVELS, 7, number of legal levels 0..NUM_LEVELS-1; legal range 2..2^ST_W-1
MAX_ERR, 3, consecutive-error count that forces LOCK (>=1)
LOCK_CYCLES, 8, cycles spent in LOCK before returning to level 0 (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
user_input  input  IN_W  command code, sampled when in_valid=1
in_valid  input  1  command qualifier
out  output  ST_W  current level; 0 while locked
locked  output  1  high while in LOCK
err_pulse  output  1  one-cycle pulse for each rejected or saturated command
illegal_flag  output  1  sticky; set when an illegal state encoding is detected

Behaviour:
- Reset, asynchronous on rst=1:
  - state=LEVEL0; out=0; locked=0; err_pulse=0; illegal_flag=0.
  - err_cnt=0; lock_cnt=0.
  - rst asserted mid-LOCK or mid-command returns to LEVEL0 immediately; no residue.
- State encoding:
  - LEVELk = k for k < NUM_LEVELS.
  - LOCK = 2^ST_W-1.
  - Every other encoding is illegal.
- Commands when in_valid=1:
  - 0 = HOLD.
  - 1 = UP.
  - 2 = DOWN.
  - 3 = CLR (go to LEVEL0).
  - Any other value = INVALID.
- in_valid=0: state, counters and outputs hold; err_pulse=0.
- Latency: a command sampled at edge n is reflected in out/locked/err_pulse after edge n.
  - All outputs are registered; no combinational input-to-output path.
- Transitions from LEVELk:
  - HOLD: stay; err_cnt unchanged.
  - UP with k < NUM_LEVELS-1: go to k+1; err_cnt=0.
  - UP with k = NUM_LEVELS-1: stay (saturate); err_pulse=1; err_cnt+1.
  - DOWN with k > 0: go to k-1; err_cnt=0.
  - DOWN with k = 0: stay (saturate); err_pulse=1; err_cnt+1.
  - CLR: go to LEVEL0; err_cnt=0.
  - INVALID: stay; err_pulse=1; err_cnt+1.
- Error counter:
  - Width is clog2(MAX_ERR+1); saturates at MAX_ERR.
  - If an error-causing command makes err_cnt reach MAX_ERR, the same edge enters LOCK.
  - On that edge: lock_cnt = LOCK_CYCLES-1; err_pulse=1; out=0; locked=1.
- LOCK:
  - All commands are ignored; err_pulse=0.
  - lock_cnt decrements each cycle.
  - In the cycle lock_cnt=0, the next edge goes to LEVEL0 with err_cnt=0 and locked=0.
  - LOCK lasts exactly LOCK_CYCLES cycles.
- Illegal encoding (fault or upset):
  - Detection overrides any command.
  - Next edge: state=LEVEL0; illegal_flag=1 (sticky until rst); err_cnt=0.
  - err_pulse is not asserted.
- Next-state logic:
  - Fully specified for every encoding and every input value.
  - Default branch assigns LEVEL0; no latches; no state can lock up.

Test Plan:
1. rst pulse, then UP x3 (in_valid=1, one per cycle) -> out = 1, 2, 3 after successive edges; err_pulse=0; locked=0.
2. From level 0: DOWN -> out stays 0, err_pulse=1 for one cycle. Then UP x6 and UP again -> out=6 and the final UP pulses err_pulse while out stays 6.
3. user_input=5, 6, 7 with in_valid=1 on consecutive cycles (MAX_ERR=3) -> err_pulse on each; locked=1 and out=0 after the third edge. Locked holds for exactly 8 cycles with UP applied throughout, then locked=0 and out=0.
4. Two INVALIDs, then a successful UP, then two INVALIDs -> no lock (err_cnt cleared by UP); locked stays 0.
5. Force state to illegal encoding 4 with NUM_LEVELS=4 -> after next edge out=0 and illegal_flag=1; illegal_flag remains 1 through later commands until rst.
6. Assert rst asynchronously mid-LOCK (lock_cnt=5) -> locked=0, out=0, err_cnt=0 immediately without waiting for clk; a normal UP after release gives out=1.

Source files
------------

// File: rtl/safe_level_fsm_if.sv
// Command/status bundle between the user command source and safe_level_fsm.
//   user_input   : command code, qualified by in_valid
//   in_valid     : command qualifier
//   out          : current level (0 while locked)
//   locked       : high while the FSM is in its timed lockout
//   err_pulse    : one-cycle pulse per rejected or saturated command
//   illegal_flag : sticky indication that an illegal state encoding was seen
// master = command source, slave = the FSM.
interface safe_level_fsm_if #(
   parameter int IN_W = 3,
   parameter int ST_W = 3
);
   logic [IN_W-1:0] user_input;
   logic            in_valid;
   logic [ST_W-1:0] out;
   logic            locked;
   logic            err_pulse;
   logic            illegal_flag;

   modport master (
      output user_input, in_valid,
      input  out, locked, err_pulse, illegal_flag
   );

   modport slave (
      input  user_input, in_valid,
      output out, locked, err_pulse, illegal_flag
   );
endinterface

// File: rtl/safe_level_fsm.sv
// Level-stepping FSM with saturating boundaries, consecutive-error counter,
// timed lockout and illegal-encoding recovery. All outputs are registered.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : safe_level_fsm_if.slave (user_input, in_valid in; out, locked,
//         err_pulse, illegal_flag out)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// LEVELk (k) | legal level k, 0 <= k < NUM_LEVELS; steps on UP/DOWN/CLR
// LOCK (all1)| lockout after MAX_ERR consecutive errors; LOCK_CYCLES cycles
// other      | illegal encoding; recovers to LEVEL0 and sets illegal_flag
module safe_level_fsm #(
   parameter int IN_W        = 3,
   parameter int ST_W        = 3,
   parameter int NUM_LEVELS  = 7,
   parameter int MAX_ERR     = 3,
   parameter int LOCK_CYCLES = 8
) (
   input logic              clk,
   input logic              rst,
   safe_level_fsm_if.slave  bus
);

   localparam int ERR_W = $clog2(MAX_ERR + 1);
   localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [ST_W-1:0] {
      LEVEL0 = {ST_W{1'b0}},
      LOCK   = {ST_W{1'b1}}
   } state_t;

   localparam logic [ST_W-1:0]  NUM_L     = ST_W'(NUM_LEVELS);
   localparam logic [ST_W-1:0]  TOP_LEVEL = ST_W'(NUM_LEVELS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(MAX_ERR);
   localparam logic [LCK_W-1:0] LOCK_LOAD = LCK_W'(LOCK_CYCLES - 1);

   localparam logic [IN_W-1:0] CMD_HOLD = IN_W'(0);
   localparam logic [IN_W-1:0] CMD_UP   = IN_W'(1);
   localparam logic [IN_W-1:0] CMD_DOWN = IN_W'(2);
   localparam logic [IN_W-1:0] CMD_CLR  = IN_W'(3);

   logic [ST_W-1:0]  state_q, state_d;
   logic [ERR_W-1:0] err_q, err_d, err_inc;
   logic [LCK_W-1:0] lock_q, lock_d;
   logic             illegal_q, illegal_d;
   logic             pulse_d, err_event;
   logic             is_level, is_lock;

   logic [ST_W-1:0]  out_q;
   logic             locked_q, pulse_q;

   assign is_level = (state_q < NUM_L);
   assign is_lock  = (state_q == LOCK);
   assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      lock_d    = lock_q;
      illegal_d = illegal_q;
      pulse_d   = 1'b0;
      err_event = 1'b0;

      unique case ({is_lock, is_level})
         2'b01: begin
            if (bus.in_valid) begin
               case (bus.user_input)
                  CMD_HOLD: ;
                  CMD_UP: begin
                     if (state_q != TOP_LEVEL) begin
                        state_d = state_q + 1'b1;
                        err_d   = '0;
                     end else begin
                        err_event = 1'b1;
                     end
                  end
                  CMD_DOWN: begin
                     if (state_q != LEVEL0) begin
                        state_d = state_q - 1'b1;
                        err_d   = '0;
                     end else begin
                        err_event = 1'b1;
                     end
                  end
                  CMD_CLR: begin
                     state_d = LEVEL0;
                     err_d   = '0;
                  end
                  default: err_event = 1'b1;
               endcase

               if (err_event) begin
                  pulse_d = 1'b1;
                  err_d   = err_inc;
                  // Reaching the limit enters LOCK on this same edge.
                  if (err_inc == ERR_MAX) begin
                     state_d = LOCK;
                     lock_d  = LOCK_LOAD;
                  end
               end
            end
         end
         2'b10: begin
            // Timer runs regardless of commands; exit after the zero cycle.
            if (lock_q == '0) begin
               state_d = LEVEL0;
               err_d   = '0;
            end else begin
               lock_d = lock_q - 1'b1;
            end
         end
         default: begin
            state_d   = LEVEL0;
            err_d     = '0;
            lock_d    = '0;
            illegal_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LEVEL0;
         err_q     <= '0;
         lock_q    <= '0;
         illegal_q <= 1'b0;
         out_q     <= '0;
         locked_q  <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         lock_q    <= lock_d;
         illegal_q <= illegal_d;
         out_q     <= (state_d == LOCK) ? '0 : state_d;
         locked_q  <= (state_d == LOCK);
         pulse_q   <= pulse_d;
      end
   end

   assign bus.out          = out_q;
   assign bus.locked       = locked_q;
   assign bus.err_pulse    = pulse_q;
   assign bus.illegal_flag = illegal_q;

endmodule

// File: tb/tb_safe_level_fsm.sv
// Directed bench for safe_level_fsm: default instance (7 levels) plus a
// 4-level instance used for illegal-encoding recovery.
module tb_safe_level_fsm;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   safe_level_fsm_if #(.IN_W(3), .ST_W(3)) bus7 ();
   safe_level_fsm_if #(.IN_W(3), .ST_W(3)) bus4 ();

   safe_level_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus7.slave)
   );

   safe_level_fsm #(.NUM_LEVELS(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one command to the 7-level DUT across one edge; sample 1 ns after.
   task automatic cmd7(input logic v, input logic [2:0] c);
      bus7.in_valid   = v;
      bus7.user_input = c;
      @(posedge clk);
      #1;
   endtask

   task automatic cmd4(input logic v, input logic [2:0] c);
      bus4.in_valid   = v;
      bus4.user_input = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk7(input string tag, input int o, input int l, input int p);
      check_val({tag, ".out"},    int'(bus7.out),       o);
      check_val({tag, ".locked"}, int'(bus7.locked),    l);
      check_val({tag, ".pulse"},  int'(bus7.err_pulse), p);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus7.in_valid   = 1'b0;
      bus7.user_input = 3'd0;
      bus4.in_valid   = 1'b0;
      bus4.user_input = 3'd0;
      rst = 1'b1;
      #12;
      check_val("rst.out",     int'(bus7.out),          0);
      check_val("rst.locked",  int'(bus7.locked),       0);
      check_val("rst.pulse",   int'(bus7.err_pulse),    0);
      check_val("rst.illegal", int'(bus7.illegal_flag), 0);
      @(negedge clk);
      rst = 1'b0;

      // Three UPs from level 0
      for (int i = 1; i <= 3; i++) begin
         cmd7(1'b1, 3'd1);
         chk7($sformatf("up%0d", i), i, 0, 0);
      end

      // in_valid low holds everything
      cmd7(1'b0, 3'd1);
      chk7("idle", 3, 0, 0);

      // DOWN saturates at 0
      cmd7(1'b1, 3'd3);
      chk7("clr", 0, 0, 0);
      cmd7(1'b1, 3'd2);
      chk7("down_sat", 0, 0, 1);
      cmd7(1'b1, 3'd0);
      chk7("hold", 0, 0, 0);

      // Climb to top, then UP saturates
      for (int i = 1; i <= 6; i++) begin
         cmd7(1'b1, 3'd1);
         check_val($sformatf("climb%0d", i), int'(bus7.out), i);
      end
      cmd7(1'b1, 3'd1);
      chk7("up_sat", 6, 0, 1);
      cmd7(1'b1, 3'd2);
      chk7("down_top", 5, 0, 0);

      // Two errors, success clears, two errors: no lock
      cmd7(1'b1, 3'd3);
      cmd7(1'b1, 3'd5);
      chk7("inv_a1", 0, 0, 1);
      cmd7(1'b1, 3'd6);
      chk7("inv_a2", 0, 0, 1);
      cmd7(1'b1, 3'd1);
      chk7("inv_up", 1, 0, 0);
      cmd7(1'b1, 3'd4);
      chk7("inv_b1", 1, 0, 1);
      cmd7(1'b1, 3'd7);
      chk7("inv_b2", 1, 0, 1);
      cmd7(1'b1, 3'd3);
      chk7("inv_clr", 0, 0, 0);

      // Three consecutive INVALIDs -> LOCK for exactly 8 cycles
      cmd7(1'b1, 3'd5);
      chk7("lk_e1", 0, 0, 1);
      cmd7(1'b1, 3'd6);
      chk7("lk_e2", 0, 0, 1);
      cmd7(1'b1, 3'd7);
      chk7("lk_e3", 0, 1, 1);
      for (int i = 2; i <= 8; i++) begin
         cmd7(1'b1, 3'd1);
         chk7($sformatf("lk_c%0d", i), 0, 1, 0);
      end
      cmd7(1'b1, 3'd1);
      chk7("lk_exit", 0, 0, 0);
      cmd7(1'b1, 3'd1);
      chk7("lk_after_up", 1, 0, 0);

      // Async reset mid-LOCK
      cmd7(1'b1, 3'd5);
      cmd7(1'b1, 3'd5);
      cmd7(1'b1, 3'd5);
      check_val("ar.locked_pre", int'(bus7.locked), 1);
      cmd7(1'b0, 3'd0);
      cmd7(1'b0, 3'd0);
      check_val("ar.lock_cnt", int'(dut.lock_q), 5);
      #2;
      rst = 1'b1;
      #1;
      check_val("ar.locked", int'(bus7.locked), 0);
      check_val("ar.out",    int'(bus7.out),    0);
      check_val("ar.err",    int'(dut.err_q),   0);
      @(negedge clk);
      rst = 1'b0;
      cmd7(1'b1, 3'd1);
      chk7("ar.up", 1, 0, 0);
      bus7.in_valid = 1'b0;

      // Illegal encoding on the 4-level instance
      cmd4(1'b1, 3'd1);
      check_val("il.up", int'(bus4.out), 1);
      @(negedge clk);
      force dut4.state_q = 3'd4;
      #1;
      release dut4.state_q;
      cmd4(1'b1, 3'd1);
      check_val("il.out",     int'(bus4.out),          0);
      check_val("il.flag",    int'(bus4.illegal_flag), 1);
      check_val("il.pulse",   int'(bus4.err_pulse),    0);
      cmd4(1'b1, 3'd1);
      check_val("il.up2",     int'(bus4.out),          1);
      check_val("il.sticky1", int'(bus4.illegal_flag), 1);
      cmd4(1'b1, 3'd2);
      cmd4(1'b1, 3'd2);
      check_val("il.sat_p",   int'(bus4.err_pulse),    1);
      check_val("il.sticky2", int'(bus4.illegal_flag), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("il.rst",     int'(bus4.illegal_flag), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
